// File: rtl/obuf_loop_iter_gen.sv
// Compute-side loop-nest sequencer. Trip counts are loaded through a per-instruction config stream.
// The nest advances one innermost iteration per un-stalled cycle and emits registered loop-exit events.
module obuf_loop_iter_gen #(
  parameter int NUM_LOOPS   = 8,
  parameter int LOOP_ID_W   = 5,
  parameter int LOOP_ITER_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done,
  input  logic                   cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  input  logic                   start,
  input  logic                   stall,
  output logic                   step_v,
  output logic                   com_loop_exit,
  output logic [LOOP_ID_W-1:0]   com_loop_index,
  output logic                   compute_done,
  output logic                   busy,
  output logic                   cfg_err
);

  localparam int CNT_W = $clog2(NUM_LOOPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       num_loops, eff_loops;
  logic [LOOP_ITER_W-1:0] limit [NUM_LOOPS];
  logic [LOOP_ITER_W-1:0] ctr   [NUM_LOOPS];
  logic [NUM_LOOPS-1:0]   active, wrap, carry;
  logic [LOOP_ID_W-1:0]   top_wrap;
  logic                   cfg_ok, cfg_bad, start_ok, do_step, last_step, compute_done_nxt;

  assign busy      = (state != IDLE);
  assign cfg_ok    = cfg_loop_iter_v && !done && (state == IDLE) && (num_loops < CNT_W'(NUM_LOOPS));
  assign cfg_bad   = cfg_loop_iter_v && !done && !cfg_ok;
  assign eff_loops = num_loops + CNT_W'(cfg_ok);
  assign start_ok  = start && !done && (state == IDLE);
  assign do_step   = (state == RUN) && !stall && !done;

  // Wrap chain: a loop wraps only when it and every loop inside it sit at their limits.
  always_comb begin
    active    = '0;
    wrap      = '0;
    carry     = '0;
    top_wrap  = '0;
    last_step = 1'b0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      active[i] = (CNT_W'(i) < num_loops);
      carry[i]  = (i == 0) ? 1'b1 : wrap[(i == 0) ? 0 : i - 1];
      wrap[i]   = active[i] && carry[i] && (ctr[i] == limit[i]);
      if (wrap[i]) top_wrap = LOOP_ID_W'(i);
      if (CNT_W'(i + 1) == num_loops) last_step = wrap[i];
    end
  end

  always_comb begin
    state_nxt        = state;
    compute_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (eff_loops == '0) begin
            state_nxt        = FINISH;
            compute_done_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN:    if (do_step && last_step) state_nxt = FINISH;
      // step_v is only high here when the last step of a real nest just retired
      FINISH: begin
        state_nxt        = IDLE;
        compute_done_nxt = step_v;
      end
      default: state_nxt = IDLE;
    endcase
    if (done) begin
      state_nxt        = IDLE;
      compute_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_loops <= '0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_LOOPS; i++) limit[i] <= '0;
    end else if (done) begin
      num_loops <= '0;
      cfg_err   <= 1'b0;
    end else begin
      if (cfg_ok) begin
        num_loops <= num_loops + CNT_W'(1);
        for (int i = 0; i < NUM_LOOPS; i++)
          if (CNT_W'(i) == num_loops) limit[i] <= cfg_loop_iter;
      end
      if (cfg_bad) cfg_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LOOPS; i++) ctr[i] <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < NUM_LOOPS; i++) ctr[i] <= '0;
    end else if (do_step) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        if (wrap[i])                    ctr[i] <= '0;
        else if (active[i] && carry[i]) ctr[i] <= ctr[i] + LOOP_ITER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_v         <= 1'b0;
      com_loop_exit  <= 1'b0;
      com_loop_index <= '0;
      compute_done   <= 1'b0;
    end else begin
      step_v        <= do_step;
      com_loop_exit <= do_step && wrap[0];
      compute_done  <= compute_done_nxt;
      if (do_step && wrap[0]) com_loop_index <= top_wrap;
    end
  end

endmodule

// File: tb/tb_obuf_loop_iter_gen.sv
// Randomized bench for obuf_loop_iter_gen; expected exit events come from a mixed-radix step-count model.
module tb_obuf_loop_iter_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        done = 1'b0;
  logic        cfg_loop_iter_v = 1'b0;
  logic [15:0] cfg_loop_iter = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        step_v, com_loop_exit, compute_done, busy, cfg_err;
  logic [4:0]  com_loop_index;

  int tests = 0;
  int fails = 0;
  int lim [8];

  obuf_loop_iter_gen #(.NUM_LOOPS(8), .LOOP_ID_W(5), .LOOP_ITER_W(16)) dut (
    .clk(clk), .reset(reset), .done(done), .cfg_loop_iter_v(cfg_loop_iter_v),
    .cfg_loop_iter(cfg_loop_iter), .start(start), .stall(stall), .step_v(step_v),
    .com_loop_exit(com_loop_exit), .com_loop_index(com_loop_index),
    .compute_done(compute_done), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic cfg_write(input int val);
    cfg_loop_iter_v = 1'b1;
    cfg_loop_iter   = 16'(val);
    tick();
    cfg_loop_iter_v = 1'b0;
  endtask

  // Step s (1-based) closes loop i when s is a multiple of the product of trip counts of loops 0..i.
  task automatic model_step(input int n, input int l [8], input int s,
                            output logic e_exit, output logic [4:0] e_idx);
    int prod;
    prod   = 1;
    e_exit = 1'b0;
    e_idx  = '0;
    for (int i = 0; i < n; i++) begin
      prod = prod * (l[i] + 1);
      if (s % prod == 0) begin
        e_idx = 5'(i);
        if (i == 0) e_exit = 1'b1;
      end
    end
  endtask

  task automatic run_nest(input string name, input int n, input int l [8], input int stall_pct,
                          input bit inject, input bit merge_start);
    int total, s, guard;
    bit st, injected;
    logic e_exit;
    logic [4:0] e_idx;
    total = 1;
    for (int i = 0; i < n; i++) total = total * (l[i] + 1);
    pulse_done();
    for (int i = 0; i < n; i++) begin
      if (merge_start && i == n - 1) start = 1'b1;
      cfg_write(l[i]);
    end
    if (!merge_start) begin
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("[TB] FAIL %s busy_after_start: got %b want 1", name, busy); end
    s = 0; guard = 0; injected = 0;
    while (s < total && guard < 4000) begin
      st    = ($urandom_range(99) < stall_pct);
      stall = st;
      if (inject && s == 2 && !injected) begin
        cfg_loop_iter_v = 1'b1;
        cfg_loop_iter   = 16'd5;
        start           = 1'b1;
        injected        = 1;
      end
      tick();
      cfg_loop_iter_v = 1'b0;
      start = 1'b0;
      tests++;
      if (step_v !== !st || compute_done !== 1'b0) begin
        fails++;
        $display("[TB] FAIL %s step_v@%0d: got step_v=%b done=%b want step_v=%b done=0",
                 name, s, step_v, compute_done, !st);
      end
      if (step_v === 1'b1) begin
        s++;
        model_step(n, l, s, e_exit, e_idx);
        tests++;
        if (com_loop_exit !== e_exit || (e_exit && com_loop_index !== e_idx)) begin
          fails++;
          $display("[TB] FAIL %s exit@step%0d: got exit=%b idx=%0d want exit=%b idx=%0d",
                   name, s, com_loop_exit, com_loop_index, e_exit, e_idx);
        end
      end
      guard++;
    end
    stall = 1'b0;
    if (guard >= 4000) begin
      fails++;
      $display("[TB] FAIL %s timeout: got %0d steps want %0d", name, s, total);
    end
    tick();
    tests++;
    if (compute_done !== 1'b1 || step_v !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s compute_done: got done=%b step_v=%b want done=1 step_v=0", name, compute_done, step_v);
    end
    tick();
    tests++;
    if (compute_done !== 1'b0 || busy !== 1'b0 || cfg_err !== inject) begin
      fails++;
      $display("[TB] FAIL %s post_done: got done=%b busy=%b cfg_err=%b want 0 0 %b",
               name, compute_done, busy, cfg_err, inject);
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({step_v, com_loop_exit, com_loop_index, compute_done, busy, cfg_err} !== 10'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b want 0", {step_v, com_loop_exit, com_loop_index, compute_done, busy, cfg_err});
    end
  endtask

  task automatic test_directed();
    lim = '{1, 2, 0, 0, 0, 0, 0, 0};
    run_nest("nest2x3", 2, lim, 0, 0, 0);
    run_nest("nest2x3_stall", 2, lim, 40, 0, 0);
    lim = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_nest("trip_zero", 3, lim, 0, 0, 0);
  endtask

  task automatic test_zero_loops();
    pulse_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (compute_done !== 1'b1 || busy !== 1'b1 || step_v !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_loops: got done=%b busy=%b step_v=%b want 1 1 0", compute_done, busy, step_v);
    end
    tick();
    tests++;
    if (compute_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_loops_end: got done=%b busy=%b want 0 0", compute_done, busy);
    end
  endtask

  task automatic test_cfg_overflow();
    pulse_done();
    for (int i = 0; i < 9; i++) begin
      cfg_write(0);
      if (i == 7) begin
        tests++;
        if (cfg_err !== 1'b0) begin fails++; $display("[TB] FAIL cfg_full: got cfg_err=%b want 0", cfg_err); end
      end
    end
    tests++;
    if (cfg_err !== 1'b1) begin fails++; $display("[TB] FAIL cfg_overflow: got cfg_err=%b want 1", cfg_err); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (step_v !== 1'b1 || com_loop_exit !== 1'b1 || com_loop_index !== 5'd7) begin
      fails++;
      $display("[TB] FAIL eight_loops: got step_v=%b exit=%b idx=%0d want 1 1 7", step_v, com_loop_exit, com_loop_index);
    end
    tick();
    pulse_done();
    tests++;
    if (cfg_err !== 1'b0) begin fails++; $display("[TB] FAIL done_clears_err: got cfg_err=%b want 0", cfg_err); end
    test_zero_loops();
  endtask

  task automatic test_busy_writes();
    lim = '{1, 2, 0, 0, 0, 0, 0, 0};
    run_nest("busy_writes", 2, lim, 0, 1, 0);
    lim = '{2, 1, 0, 0, 0, 0, 0, 0};
    run_nest("start_with_cfg", 2, lim, 0, 0, 1);
  endtask

  task automatic test_random_nests();
    int n;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) lim[i] = (i < n) ? $urandom_range(0, 3) : 0;
      run_nest("random", n, lim, 30, 0, r[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_done();
    cfg_write(1);
    cfg_write(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({step_v, com_loop_exit, com_loop_index, compute_done, busy, cfg_err} !== 10'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: got %b want 0", {step_v, com_loop_exit, com_loop_index, compute_done, busy, cfg_err});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (compute_done !== 1'b0 || step_v !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_no_done: got done=%b step_v=%b want 0 0", compute_done, step_v);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    tick();
    test_directed();
    test_zero_loops();
    test_cfg_overflow();
    test_busy_writes();
    test_random_nests();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
